// File: rtl/vga_pkg.sv
// Shared 800x600@60 timing constants and counter types for the VGA scan-out path.
package vga_pkg;
   localparam int H_VISIBLE     = 800;
   localparam int H_FP          = 40;
   localparam int H_SYNC        = 128;
   localparam int H_BP          = 88;
   localparam int V_VISIBLE     = 600;
   localparam int V_FP          = 1;
   localparam int V_SYNC        = 4;
   localparam int V_BP          = 23;
   localparam int SCREEN_WIDTH  = 32;
   localparam int SCREEN_HEIGHT = 24;
   localparam int SCALE         = 25;

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam int XW = $clog2(SCREEN_WIDTH);
   localparam int YW = $clog2(SCREEN_HEIGHT);
   localparam int SW = $clog2(SCALE);

   typedef logic [10:0]   h_cnt_t;
   typedef logic [9:0]    v_cnt_t;
   typedef logic [SW-1:0] sub_t;

   localparam h_cnt_t H_LAST     = h_cnt_t'(H_TOTAL - 1);
   localparam h_cnt_t H_VIS_END  = h_cnt_t'(H_VISIBLE);
   localparam h_cnt_t H_VIS_LAST = h_cnt_t'(H_VISIBLE - 1);
   localparam h_cnt_t HS_BEG     = h_cnt_t'(H_VISIBLE + H_FP);
   localparam h_cnt_t HS_END     = h_cnt_t'(H_VISIBLE + H_FP + H_SYNC);

   localparam v_cnt_t V_LAST     = v_cnt_t'(V_TOTAL - 1);
   localparam v_cnt_t V_VIS_END  = v_cnt_t'(V_VISIBLE);
   localparam v_cnt_t V_VIS_LAST = v_cnt_t'(V_VISIBLE - 1);
   localparam v_cnt_t VS_BEG     = v_cnt_t'(V_VISIBLE + V_FP);
   localparam v_cnt_t VS_END     = v_cnt_t'(V_VISIBLE + V_FP + V_SYNC);

   localparam sub_t SUB_LAST = sub_t'(SCALE - 1);
endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with undelayed sync/active decode and the registered vblank pulse.
module vga_timing_gen
   import vga_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   output logic [10:0] o_h_cnt,
   output logic [9:0]  o_v_cnt,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_active,
   output logic        o_vblank_start
);
   h_cnt_t r_h_cnt;
   v_cnt_t r_v_cnt;
   logic   r_vblank;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_h_cnt  <= '0;
         r_v_cnt  <= '0;
         r_vblank <= 1'b0;
      end else begin
         if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
         r_vblank <= (r_h_cnt == '0) && (r_v_cnt == V_VIS_END);
      end
   end

   assign o_h_cnt        = r_h_cnt;
   assign o_v_cnt        = r_v_cnt;
   assign o_hsync        = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
   assign o_vsync        = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
   assign o_active       = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
   assign o_vblank_start = r_vblank;
endmodule

// File: rtl/vga_scan_out.sv
// 32x24 -> 800x600 x25 upscaling scan-out; 3-cycle counter-to-pin latency.
// Optional TEST_PATTERN_EN adds a test_pattern input selecting a checkerboard.
module vga_scan_out
   import vga_pkg::*;
(
   input  logic                CLK_40,
   input  logic                reset,
`ifdef TEST_PATTERN_EN
   input  logic                test_pattern,
`endif
   output logic [XW-1:0]       rd_x,
   output logic [YW-1:0]       rd_y,
   output logic                rd_en,
   input  logic                pixel_data_in,
   output logic                vblank_start,
   output logic                VGA_HS,
   output logic                VGA_VS,
   output logic [3:0]          VGA_R,
   output logic [3:0]          VGA_G,
   output logic [3:0]          VGA_B
);
   logic [10:0] w_h_cnt;
   logic [9:0]  w_v_cnt;
   logic        w_hsync;
   logic        w_vsync;
   logic        w_active;
   logic        w_pix;

   sub_t          r_h_sub, r_v_sub;
   logic [XW-1:0] r_src_x, r_rd_x;
   logic [YW-1:0] r_src_y, r_rd_y;
   logic          r_rd_en;
   logic          r_hs_d1, r_vs_d1;
   logic          r_hs_d2, r_vs_d2, r_act_d2;
   logic          r_hs, r_vs;
   logic [3:0]    r_rgb;

   vga_timing_gen u_timing (
      .i_clk          (CLK_40),
      .i_reset        (reset),
      .o_h_cnt        (w_h_cnt),
      .o_v_cnt        (w_v_cnt),
      .o_hsync        (w_hsync),
      .o_vsync        (w_vsync),
      .o_active       (w_active),
      .o_vblank_start (vblank_start)
   );

   // Sub-pixel counters track h_cnt/SCALE and v_cnt/SCALE without a divider.
   always_ff @(posedge CLK_40) begin
      if (reset) begin
         r_h_sub <= '0;
         r_src_x <= '0;
         r_v_sub <= '0;
         r_src_y <= '0;
      end else begin
         if (w_h_cnt == H_VIS_LAST) begin
            r_h_sub <= '0;
            r_src_x <= '0;
         end else if (w_h_cnt < H_VIS_END) begin
            if (r_h_sub == SUB_LAST) begin
               r_h_sub <= '0;
               r_src_x <= r_src_x + 1'b1;
            end else begin
               r_h_sub <= r_h_sub + 1'b1;
            end
         end
         if (w_h_cnt == H_LAST) begin
            if (w_v_cnt == V_VIS_LAST) begin
               r_v_sub <= '0;
               r_src_y <= '0;
            end else if (w_v_cnt < V_VIS_END) begin
               if (r_v_sub == SUB_LAST) begin
                  r_v_sub <= '0;
                  r_src_y <= r_src_y + 1'b1;
               end else begin
                  r_v_sub <= r_v_sub + 1'b1;
               end
            end
         end
      end
   end

   // rd_en doubles as the first stage of the active delay line.
   always_ff @(posedge CLK_40) begin
      if (reset) begin
         r_rd_x   <= '0;
         r_rd_y   <= '0;
         r_rd_en  <= 1'b0;
         r_hs_d1  <= 1'b0;
         r_vs_d1  <= 1'b0;
         r_hs_d2  <= 1'b0;
         r_vs_d2  <= 1'b0;
         r_act_d2 <= 1'b0;
         r_hs     <= 1'b0;
         r_vs     <= 1'b0;
         r_rgb    <= '0;
      end else begin
         r_rd_x   <= r_src_x;
         r_rd_y   <= r_src_y;
         r_rd_en  <= w_active;
         r_hs_d1  <= w_hsync;
         r_vs_d1  <= w_vsync;
         r_hs_d2  <= r_hs_d1;
         r_vs_d2  <= r_vs_d1;
         r_act_d2 <= r_rd_en;
         r_hs     <= r_hs_d2;
         r_vs     <= r_vs_d2;
         r_rgb    <= (r_act_d2 && w_pix) ? 4'hF : 4'h0;
      end
   end

`ifdef TEST_PATTERN_EN
   logic r_tp_d2;

   always_ff @(posedge CLK_40) begin
      if (reset) r_tp_d2 <= 1'b0;
      else       r_tp_d2 <= r_rd_x[0] ^ r_rd_y[0];
   end

   assign w_pix = test_pattern ? r_tp_d2 : pixel_data_in;
`else
   assign w_pix = pixel_data_in;
`endif

   assign rd_x   = r_rd_x;
   assign rd_y   = r_rd_y;
   assign rd_en  = r_rd_en;
   assign VGA_HS = r_hs;
   assign VGA_VS = r_vs;
   assign VGA_R  = r_rgb;
   assign VGA_G  = r_rgb;
   assign VGA_B  = r_rgb;
endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: raster-position model plus directed literal checks.
module tb_vga_scan_out;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tp = 1'b0;
   logic       pixel_data_in = 1'b0;
   logic [4:0] rd_x;
   logic [4:0] rd_y;
   logic       rd_en, vblank_start, VGA_HS, VGA_VS;
   logic [3:0] VGA_R, VGA_G, VGA_B;

   int checks = 0;
   int errors = 0;
   int k = 0;
   int mode = 0;
   bit chk_on = 1'b0;
   logic [4:0] la_x, la_y;

   vga_scan_out dut (
      .CLK_40        (clk),
      .reset         (reset),
`ifdef TEST_PATTERN_EN
      .test_pattern  (tp),
`endif
      .rd_x          (rd_x),
      .rd_y          (rd_y),
      .rd_en         (rd_en),
      .pixel_data_in (pixel_data_in),
      .vblank_start  (vblank_start),
      .VGA_HS        (VGA_HS),
      .VGA_VS        (VGA_VS),
      .VGA_R         (VGA_R),
      .VGA_G         (VGA_G),
      .VGA_B         (VGA_B)
   );

   always #5 clk = ~clk;

   // k = raster position the counters hold after this edge
   always @(posedge clk) k <= reset ? 0 : k + 1;

   // mode 0: all ones, 1: single pixel (5,3), 2: all zero
   function automatic bit frame(input int x, input int y);
      case (mode)
         0:       return 1'b1;
         1:       return (x == 5) && (y == 3);
         default: return 1'b0;
      endcase
   endfunction

   // synchronous RAM, one cycle read latency
   initial begin
      forever begin
         @(negedge clk);
         la_x = rd_x;
         la_y = rd_y;
         @(posedge clk);
         #1;
         pixel_data_in = frame(int'(la_x), int'(la_y));
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors < 40)
            $display("FAIL %s k=%0d got %0h want %0h", nm, k, act, exp);
      end
   endtask

   // model: position p -> (p%1056, p/1056); rd_* reflect p=k-1, pins p=k-3
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            int p1, p3, h, v, e_en, e_vb, e_hs, e_vs, e_rgb;
            bit on;
            p1 = k - 1;
            p3 = k - 3;
            e_en = 0; e_vb = 0; e_hs = 0; e_vs = 0; e_rgb = 0;
            if (p1 >= 0) begin
               h = p1 % 1056;
               v = (p1 / 1056) % 628;
               e_en = (h < 800 && v < 600) ? 1 : 0;
               e_vb = (h == 0 && v == 600) ? 1 : 0;
               if (e_en == 1) begin
                  chk("rd_x", int'(rd_x), h / 25);
                  chk("rd_y", int'(rd_y), v / 25);
               end
            end
            if (p3 >= 0) begin
               h = p3 % 1056;
               v = (p3 / 1056) % 628;
               e_hs = (h >= 840 && h < 968) ? 1 : 0;
               e_vs = (v >= 601 && v < 605) ? 1 : 0;
               on = 1'b0;
               if (h < 800 && v < 600)
                  on = tp ? bit'(((h / 25) ^ (v / 25)) & 1)
                          : frame(h / 25, v / 25);
               e_rgb = on ? 'hFFF : 0;
            end
            chk("rd_en", int'(rd_en), e_en);
            chk("vblank", int'(vblank_start), e_vb);
            chk("hs", int'(VGA_HS), e_hs);
            chk("vs", int'(VGA_VS), e_vs);
            chk("rgb", int'({VGA_R, VGA_G, VGA_B}), e_rgb);
         end
      end
   end

   task automatic wait_k(input int n);
      int g = 0;
      while (k < n && g < 100000) begin
         @(negedge clk);
         g++;
      end
      if (k != n) begin
         errors++;
         $display("FAIL wait_k got %0d want %0d", k, n);
      end
   endtask

   task automatic do_reset(input int cyc, input int new_mode);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      mode = new_mode;
      chk_on = 1'b1;
      chk("rst_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
      chk("rst_sync", int'({VGA_HS, VGA_VS, vblank_start, rd_en}), 0);
      repeat (cyc - 1) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      do_reset(2, 0);
      wait_k(1);    chk("l_en0", int'(rd_en), 1);
      wait_k(3);    chk("l_w0", int'(VGA_R), 15);
      wait_k(26);   chk("l_x1", int'(rd_x), 1);
      wait_k(800);  chk("l_x31", int'(rd_x), 31);
      wait_k(801);  chk("l_enlo", int'(rd_en), 0);
      wait_k(802);  chk("l_wlast", int'(VGA_R), 15);
      wait_k(803);  chk("l_blk", int'(VGA_R), 0);
      wait_k(842);  chk("l_hs_lo", int'(VGA_HS), 0);
      wait_k(843);  chk("l_hs_hi", int'(VGA_HS), 1);
      wait_k(970);  chk("l_hs_end", int'(VGA_HS), 1);
      wait_k(971);  chk("l_hs_off", int'(VGA_HS), 0);
      wait_k(1899); chk("l_hs_per", int'(VGA_HS), 1);

      do_reset(1, 1);
      wait_k(25 * 1056 + 1);   chk("l_y1", int'(rd_y), 1);
      wait_k(74 * 1056 + 128); chk("l_ln74", int'(VGA_R), 0);
      wait_k(75 * 1056 + 1);   chk("l_y3", int'(rd_y), 3);
      wait_k(75 * 1056 + 127); chk("l_pre", int'(VGA_G), 0);
      wait_k(75 * 1056 + 128); chk("l_lit", int'(VGA_G), 15);
      wait_k(75 * 1056 + 152); chk("l_litend", int'(VGA_B), 15);
      wait_k(75 * 1056 + 153); chk("l_post", int'(VGA_B), 0);
      wait_k(76 * 1056 + 400);
      do_reset(3, 1);
      wait_k(842);  chk("r_hs_lo", int'(VGA_HS), 0);
      wait_k(843);  chk("r_hs_hi", int'(VGA_HS), 1);
      wait_k(1100);

`ifdef TEST_PATTERN_EN
      do_reset(1, 2);
      tp = 1'b1;
      wait_k(27);   chk("t_blk", int'(VGA_R), 0);
      wait_k(28);   chk("t_wht", int'(VGA_R), 15);
      wait_k(25 * 1056 + 3); chk("t_inv", int'(VGA_R), 15);
      wait_k(26 * 1056 + 100);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
